button_cmd_scheduler: RTL and testbench
=======================================

# button_cmd_scheduler

Scans the board pushbuttons with one shared sample-tick generator, debounces each button and turns every clean press into a command ID. A round-robin arbiter merges simultaneous presses into a small command FIFO, which the multiplier control FSM drains over a valid/ready handshake. It replaces the per-button divider, debouncer, synchronizer and edge-detector chains, so all button traffic reaches the multiplier as one ordered command stream in the system clock domain.

## Interface
- NBTN, 4: number of pushbuttons; command ID = button index.
- TICK_DIV, 250000: clk cycles per debounce sample (400 Hz at 100 MHz); ≥ 2.
- DEB_SAMPLES, 4: consecutive equal samples needed to change a stable level; ≥ 2.
- FIFO_DEPTH, 4: command FIFO entries; power of two.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn  input  NBTN  raw, asynchronous button levels; active-high.
- cmd_ready  input  1  consumer accepts the head command this cycle.
- ovf_clr  input  1  synchronous clear of ovf.
- cmd_valid  output  1  FIFO not empty.
- cmd_id  output  clog2(NBTN)  head command ID; valid only while cmd_valid = 1.
- btn_level  output  NBTN  debounced stable level per button.
- ovf  output  1  sticky flag: a press was dropped.

## Operation
- Reset (rst = 0): tick counter, synchronizers, sample histories, btn_level, pending, rr pointer, FIFO pointers and count, and ovf all go to 0. Outputs: cmd_valid = 0, cmd_id = 0, btn_level = 0, ovf = 0.
- Synchronizer: each btn bit passes through a 2-FF synchronizer.
- Tick: the counter runs 0..TICK_DIV-1 and wraps. tick = 1 for the one cycle with count = TICK_DIV-1.
- Debounce: on tick, each button shifts its synchronized value into a DEB_SAMPLES-bit history.
  - History all ones: btn_level[i] becomes 1.
  - History all zeros: btn_level[i] becomes 0.
  - Otherwise btn_level[i] holds.
- Press detect: btn_level[i] going 0→1 (compared with its 1-cycle-delayed copy) sets pending[i] on the next edge. A 1→0 transition produces nothing.
- Press into a busy slot: a press while pending[i] is already 1 is dropped and sets ovf.
- ovf clearing: ovf clears only on ovf_clr = 1 or reset. If set and clear coincide, set wins.
- Arbiter: when pending ≠ 0 and FIFO count < FIFO_DEPTH, it grants the first set bit searching rr, rr+1, … modulo NBTN.
  - The granted ID is written to the FIFO and its pending bit is cleared.
  - rr ← (grant+1) mod NBTN.
  - At most one push per cycle. A full FIFO holds the pending bits.
  - A pending set and a grant for the same bit in the same cycle: the new press re-sets pending and is not dropped.
- FIFO: pop when cmd_valid & cmd_ready.
  - Push and pop in the same cycle: count unchanged.
  - A push is gated on the registered count, so a full FIFO with a pop that cycle still pushes nothing.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_ready while empty has no effect.
- Mid-operation reset: all queued and pending commands are discarded. A button held through reset restarts from level 0 and is reported as a new press once DEB_SAMPLES high samples are taken.

## Timing
- Synchronizer latency: 2 clk cycles.
- Debounce latency: the stable level changes on the tick edge that takes the DEB_SAMPLES-th consecutive equal sample.
- btn_level: visible 1 cycle after that edge.
- Press to command: with an empty FIFO and no competing pending bits, cmd_valid rises exactly 3 cycles after that tick edge. Sequence: level visible, then pending visible, then FIFO entry visible.
- cmd_id/cmd_valid: registered outputs, stable while cmd_valid = 1 and cmd_ready = 0. The next entry appears the cycle after a pop.
- Throughput: one command pushed per cycle, one popped per cycle.

## Test plan
Bench parameters: TICK_DIV = 4, DEB_SAMPLES = 3, NBTN = 4, FIFO_DEPTH = 4.
- Reset: hold rst = 0 with random btn → all outputs 0. Release with btn = 0 → no cmd_valid for 100 cycles.
- Clean press: btn[0] held high for 40 cycles with cmd_ready = 1 → exactly one cmd_valid pulse, cmd_id = 0, 3 cycles after the 3rd high-sample tick. Release → btn_level[0] falls, no command.
- Bounce: btn[1] toggles every 5 cycles for 60 cycles, then stays high → btn_level[1] never rises during bouncing. Exactly one command, cmd_id = 1.
- Simultaneous: btn[0], btn[2], btn[3] rise on the same cycle, rr = 0, cmd_ready = 1 → IDs 0, 2, 3 on consecutive cycles, then rr = 0.
- Full/overflow: with cmd_ready = 0:
  - press all four → FIFO full.
  - release and press btn[0] → pending[0] held.
  - press btn[0] again → ovf = 1.
  - raise cmd_ready → IDs 0, 1, 2, 3, 0 drained.
  - ovf_clr → ovf = 0.
- Async reset: two entries queued and btn[2] held → pulse rst low mid-cycle → cmd_valid drops immediately and nothing stale appears. btn[2] yields one new cmd_id = 2 after 3 high samples.

Source files
------------

// File: rtl/button_cmd_scheduler.sv
// Debounces NBTN pushbuttons on a shared sample tick and queues each clean press as a command ID.
// cmd_valid rises 3 cycles after the deciding sample tick; a full FIFO holds pending presses, repeats set ovf.
module button_cmd_scheduler #(
  parameter int NBTN        = 4,
  parameter int TICK_DIV    = 250000,
  parameter int DEB_SAMPLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NBTN-1:0]         btn_i,
  input  logic                    cmd_ready_i,
  input  logic                    ovf_clr_i,
  output logic                    cmd_valid_o,
  output logic [$clog2(NBTN)-1:0] cmd_id_o,
  output logic [NBTN-1:0]         btn_level_o,
  output logic                    ovf_o
);

  localparam int IDW = $clog2(NBTN);
  localparam int CW  = $clog2(TICK_DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [NBTN-1:0]        sync1_q, sync2_q;
  logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   tick;
  logic [DEB_SAMPLES-1:0] hist_q [NBTN];
  logic [DEB_SAMPLES-1:0] hist_d [NBTN];
  logic [NBTN-1:0]        level_q, level_d, level_dly_q, rise;
  logic [NBTN-1:0]        pending_q, pending_d, gnt_vec;
  logic [IDW-1:0]         rr_q, rr_d, gnt_id;
  logic                   gnt_vld;
  logic                   ovf_q, ovf_d, drop;
  logic [IDW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [PW:0]            fcnt_q, fcnt_d;
  logic                   valid_q, pop;
  int                     idx;

  always_comb begin
    tick       = (tick_cnt_q == CW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Level follows the registered history, so it lands one cycle after the deciding tick.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      hist_d[i]  = tick ? {hist_q[i][DEB_SAMPLES-2:0], sync2_q[i]} : hist_q[i];
      level_d[i] = (&hist_q[i]) ? 1'b1 : ((~|hist_q[i]) ? 1'b0 : level_q[i]);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NBTN; k++) begin
      idx = (int'(rr_q) + k) % NBTN;
      if (!gnt_vld && pending_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    if (fcnt_q == (PW+1)'(FIFO_DEPTH)) gnt_vld = 1'b0;
  end

  // A press landing on a bit granted this cycle is re-queued, not dropped.
  always_comb begin
    rise      = level_q & ~level_dly_q;
    gnt_vec   = gnt_vld ? (NBTN'(1) << gnt_id) : '0;
    pending_d = (pending_q & ~gnt_vec) | rise;
    drop      = |(rise & pending_q & ~gnt_vec);
    ovf_d     = drop | (ovf_q & ~ovf_clr_i);
    rr_d      = rr_q;
    if (gnt_vld) rr_d = (gnt_id == IDW'(NBTN - 1)) ? '0 : gnt_id + 1'b1;
    pop       = valid_q & cmd_ready_i;
    fcnt_d    = fcnt_q;
    if (gnt_vld && !pop) fcnt_d = fcnt_q + 1'b1;
    else if (!gnt_vld && pop) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      tick_cnt_q  <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pending_q   <= '0;
      rr_q        <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      valid_q     <= 1'b0;
      for (int i = 0; i < NBTN; i++) hist_q[i] <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      tick_cnt_q  <= tick_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      ovf_q       <= ovf_d;
      fcnt_q      <= fcnt_d;
      valid_q     <= (fcnt_d != '0);
      for (int i = 0; i < NBTN; i++) hist_q[i] <= hist_d[i];
      if (gnt_vld) begin
        mem_q[wr_ptr_q] <= gnt_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign cmd_valid_o = valid_q;
  assign cmd_id_o    = mem_q[rd_ptr_q];
  assign btn_level_o = level_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Bench for button_cmd_scheduler: table of press patterns plus reset, bounce, overflow and async-reset sequences.
module tb_button_cmd_scheduler;

  localparam int NBTN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       cmd_ready, ovf_clr;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [3:0] btn_level;
  logic       ovf;

  button_cmd_scheduler #(
    .NBTN(NBTN), .TICK_DIV(4), .DEB_SAMPLES(3), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .btn_i(btn), .cmd_ready_i(cmd_ready),
    .ovf_clr_i(ovf_clr), .cmd_valid_o(cmd_valid), .cmd_id_o(cmd_id),
    .btn_level_o(btn_level), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      mask;
    int              n;
    logic [3:0][1:0] ids;
  } vec_t;

  int total = 0, bad = 0;
  int edge_n = 0, pop_cnt = 0, first_vld = -1, first_lvl = -1;
  logic [1:0] exp_q[$];
  int pop_edges[$];
  vec_t tbl[7];

  function automatic vec_t mk(input logic [3:0] m, input int n,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, input logic [1:0] d);
    vec_t v;
    v.mask = m; v.n = n;
    v.ids[0] = a; v.ids[1] = b; v.ids[2] = c; v.ids[3] = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outputs are inspected at the negedge; a valid&ready seen here is the pop at the next posedge.
  task automatic cyc();
    if (cmd_valid && first_vld < 0) first_vld = edge_n;
    if (btn_level[0] && first_lvl < 0) first_lvl = edge_n;
    if (cmd_valid && cmd_ready) begin
      pop_cnt++;
      pop_edges.push_back(edge_n);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_cmd: got id %0d expected none", cmd_id);
      end else begin
        check("cmd_id", 32'(cmd_id), 32'(exp_q.pop_front()));
      end
    end
    @(negedge clk);
    edge_n++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int e0, s1, p0, viol;
    tbl[0] = mk(4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);
    tbl[1] = mk(4'b1101, 3, 2'd0, 2'd2, 2'd3, 2'd0);
    tbl[2] = mk(4'b1001, 2, 2'd0, 2'd3, 2'd0, 2'd0);
    tbl[3] = mk(4'b0110, 2, 2'd1, 2'd2, 2'd0, 2'd0);
    tbl[4] = mk(4'b0011, 2, 2'd0, 2'd1, 2'd0, 2'd0);
    tbl[5] = mk(4'b1010, 2, 2'd3, 2'd1, 2'd0, 2'd0);
    tbl[6] = mk(4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);

    rst_n = 1'b0; btn = '0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      btn = 4'($urandom_range(0, 15));
    end
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_id", 32'(cmd_id), 0);
    check("rst_level", 32'(btn_level), 0);
    check("rst_ovf", 32'(ovf), 0);

    @(negedge clk);
    btn = '0; rst_n = 1'b1; edge_n = 0;
    first_vld = -1;
    run(100);
    check("idle_no_valid", 32'(first_vld), 32'(-1));

    // Clean press: timing relative to the free-running sample tick.
    cmd_ready = 1'b1; first_vld = -1; first_lvl = -1; p0 = pop_cnt;
    e0 = edge_n;
    s1 = ((e0 + 6) / 4) * 4;
    btn = 4'b0001; exp_q.push_back(2'd0);
    run(40);
    check("clean_valid_edge", 32'(first_vld), 32'(s1 + 11));
    check("clean_level_edge", 32'(first_lvl), 32'(s1 + 9));
    check("clean_level_hi", 32'(btn_level), 32'b0001);
    btn = '0;
    run(30);
    check("clean_level_lo", 32'(btn_level), 0);
    check("clean_pops", 32'(pop_cnt - p0), 1);

    // Bounce: 5-cycle halves never span three equal samples.
    p0 = pop_cnt; viol = 0;
    for (int ph = 0; ph < 12; ph++) begin
      btn[1] = (ph % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        if (btn_level[1]) viol++;
        cyc();
      end
    end
    check("bounce_no_level", 32'(viol), 0);
    btn = 4'b0010; exp_q.push_back(2'd1);
    run(40);
    check("bounce_level_hi", 32'(btn_level), 32'b0010);
    btn = '0;
    run(30);
    check("bounce_pops", 32'(pop_cnt - p0), 1);

    for (int r = 0; r < 7; r++) begin
      pop_edges.delete();
      p0 = pop_cnt;
      btn = tbl[r].mask;
      for (int j = 0; j < tbl[r].n; j++) exp_q.push_back(tbl[r].ids[j]);
      run(40);
      check("tbl_level_hi", 32'(btn_level), 32'(tbl[r].mask));
      btn = '0;
      run(30);
      check("tbl_level_lo", 32'(btn_level), 0);
      check("tbl_pops", 32'(pop_cnt - p0), 32'(tbl[r].n));
      if (tbl[r].n > 1 && pop_edges.size() >= tbl[r].n)
        check("tbl_back_to_back", 32'(pop_edges[tbl[r].n-1] - pop_edges[0]), 32'(tbl[r].n - 1));
    end
    check("tbl_queue_empty", 32'(exp_q.size()), 0);

    // Full FIFO, held pending press, then a dropped press.
    cmd_ready = 1'b0;
    btn = 4'b1111;
    for (int j = 0; j < 4; j++) exp_q.push_back(2'(j));
    run(40);
    check("full_valid", 32'(cmd_valid), 1);
    check("full_head", 32'(cmd_id), 0);
    btn = '0;
    run(30);
    btn = 4'b0001; exp_q.push_back(2'd0);
    run(40);
    check("held_no_ovf", 32'(ovf), 0);
    check("held_head_stable", 32'(cmd_id), 0);
    btn = '0;
    run(30);
    btn = 4'b0001;
    run(40);
    check("drop_ovf", 32'(ovf), 1);
    btn = '0;
    run(30);
    pop_edges.delete();
    p0 = pop_cnt;
    cmd_ready = 1'b1;
    run(20);
    check("drain_pops", 32'(pop_cnt - p0), 5);
    if (pop_edges.size() >= 5)
      check("drain_back_to_back", 32'(pop_edges[4] - pop_edges[0]), 4);
    check("drain_queue_empty", 32'(exp_q.size()), 0);
    check("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);

    // Async reset with entries queued and btn[2] held through it.
    cmd_ready = 1'b0;
    btn = 4'b1010; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    run(40);
    check("pre_rst_valid", 32'(cmd_valid), 1);
    check("pre_rst_head", 32'(cmd_id), 1);
    btn = 4'b0100;
    run(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(cmd_valid), 0);
    check("arst_id", 32'(cmd_id), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("arst_level", 32'(btn_level), 0);
    rst_n = 1'b1; edge_n = 0; first_vld = -1;
    cmd_ready = 1'b1; p0 = pop_cnt;
    exp_q.push_back(2'd2);
    run(40);
    check("post_rst_valid_edge", 32'(first_vld), 15);
    check("post_rst_pops", 32'(pop_cnt - p0), 1);
    check("post_rst_level", 32'(btn_level), 32'b0100);
    check("post_rst_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
